// File: rtl/ctrl_seq_pkg.sv
// Shared types and default divisors for the frame sequencer.
// State encoding is kept here so every block and test view agrees on it.
package ctrl_seq_pkg;

    typedef enum logic [2:0] {
        ST_LATCH  = 3'd0,
        ST_LOAD   = 3'd1,
        ST_GAP    = 3'd2,
        ST_WAIT   = 3'd3,
        ST_SETTLE = 3'd4
    } ctrl_seq_state_t;

    localparam int CTRL_SEQ_DIV_A_DEF = 750;
    localparam int CTRL_SEQ_DIV_B_DEF = 512;

endpackage

// File: rtl/ctrl_prescaler.sv
// Gate-tick prescaler: wrapping counter with run-time divisor select; o_cnt_en is
// combinational from the counter register. No backpressure, free-running.
module ctrl_prescaler #(
    parameter int SCALER_W = 10,
    parameter int DIV_A    = 750,
    parameter int DIV_B    = 512
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_freq,
    output logic o_cnt_en
);

    if (DIV_A < 2 || DIV_A > (1 << SCALER_W)) begin : g_bad_div_a
        $error("ctrl_prescaler: DIV_A out of range for SCALER_W");
    end
    if (DIV_B < 2 || DIV_B > (1 << SCALER_W)) begin : g_bad_div_b
        $error("ctrl_prescaler: DIV_B out of range for SCALER_W");
    end

    localparam logic [SCALER_W-1:0] DIV_A_M1 = SCALER_W'(DIV_A - 1);
    localparam logic [SCALER_W-1:0] DIV_B_M1 = SCALER_W'(DIV_B - 1);

    logic [SCALER_W-1:0] scaler_q;
    logic [SCALER_W-1:0] scaler_d;
    logic [SCALER_W-1:0] div_m1;

    assign div_m1 = i_freq ? DIV_A_M1 : DIV_B_M1;

    // >= rather than == so a switch to the smaller divisor wraps immediately.
    always_comb begin
        scaler_d = scaler_q + SCALER_W'(1);
        if (scaler_q >= div_m1) begin
            scaler_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            scaler_q <= '0;
        end else begin
            scaler_q <= scaler_d;
        end
    end

    assign o_cnt_en = (scaler_q == '0);

endmodule

// File: rtl/ctrl_seq.sv
// Frame sequencer: per tick, walks NUM_CH channels with a load/busy handshake, then latches.
// Latency: tick -> o_srload next cycle, 3 cycles/channel min; WAIT stalls while i_srbusy. One-shot via CTRL_SEQ_ONESHOT_EN.
module ctrl_seq
    import ctrl_seq_pkg::*;
#(
    parameter int NUM_CH   = 5,
    parameter int SCALER_W = 10,
    parameter int DIV_A    = CTRL_SEQ_DIV_A_DEF,
    parameter int DIV_B    = CTRL_SEQ_DIV_B_DEF,
    parameter int MUX_W    = $clog2(NUM_CH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_freq,
    input  logic             i_srbusy,
    output logic [MUX_W-1:0] o_muxsel,
    output logic             o_srload,
    output logic             o_latch,
    output logic             o_cnt_en,
    output logic             o_overrun
`ifdef CTRL_SEQ_ONESHOT_EN
    ,
    input  logic             i_trig
`endif
);

    if (NUM_CH < 2) begin : g_bad_num_ch
        $error("ctrl_seq: NUM_CH must be at least 2");
    end

    localparam logic [MUX_W-1:0] LAST_CH = MUX_W'(NUM_CH - 1);

    ctrl_seq_state_t  state_q, state_d;
    logic [MUX_W-1:0] ch_q, ch_d;
    logic             cnt_en;
    logic             go;

    ctrl_prescaler #(
        .SCALER_W (SCALER_W),
        .DIV_A    (DIV_A),
        .DIV_B    (DIV_B)
    ) u_prescaler (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_freq   (i_freq),
        .o_cnt_en (cnt_en)
    );

`ifdef CTRL_SEQ_ONESHOT_EN
    logic armed_q, armed_d;

    // A trigger coinciding with the tick starts the frame without waiting for armed.
    assign go        = cnt_en && (armed_q || i_trig);
    assign o_overrun = i_trig && (state_q != ST_LATCH);

    always_comb begin
        armed_d = armed_q;
        if (state_q == ST_LATCH) begin
            if (go) begin
                armed_d = 1'b0;
            end else if (i_trig) begin
                armed_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            armed_q <= 1'b0;
        end else begin
            armed_q <= armed_d;
        end
    end
`else
    assign go        = cnt_en;
    assign o_overrun = cnt_en && (state_q != ST_LATCH);
`endif

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        case (state_q)
            ST_LATCH: begin
                ch_d = '0;
                if (go) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD:  state_d = ST_GAP;
            // Busy is not yet valid here: the register needs a cycle to raise it.
            ST_GAP:   state_d = ST_WAIT;
            ST_WAIT: begin
                if (!i_srbusy) begin
                    if (ch_q == LAST_CH) begin
                        state_d = ST_SETTLE;
                    end else begin
                        ch_d    = ch_q + MUX_W'(1);
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_SETTLE: begin
                ch_d    = '0;
                state_d = ST_LATCH;
            end
            default: begin
                ch_d    = '0;
                state_d = ST_LATCH;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_LATCH;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
        end
    end

    assign o_srload = (state_q == ST_LOAD);
    assign o_latch  = (state_q == ST_LATCH);
    assign o_muxsel = ch_q;
    assign o_cnt_en = cnt_en;

endmodule

// File: tb/tb_ctrl_seq.sv
// Bench for ctrl_seq: cycle-level scoreboard model plus directed scenarios with literal expectations.
module tb_ctrl_seq;

    localparam int NUM_CH = 5;
    localparam int DIV_A  = 750;
    localparam int DIV_B  = 512;
`ifdef CTRL_SEQ_ONESHOT_EN
    localparam bit ONESHOT = 1'b1;
`else
    localparam bit ONESHOT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       freq = 1'b0;
    logic       srbusy = 1'b0;
    logic       trig = 1'b0;
    logic [2:0] muxsel;
    logic       srload, latch, cnt_en, overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int busy_len = 0;
    bit force_busy = 1'b0;

    // Model state: frame-level view driven by cycle numbers, not a state machine.
    int m_sc, m_ch, m_cyc, m_load, m_end;
    bit m_in, m_armed;

    always #5 clk = ~clk;

    ctrl_seq #(
        .NUM_CH   (NUM_CH),
        .SCALER_W (10),
        .DIV_A    (DIV_A),
        .DIV_B    (DIV_B)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_freq    (freq),
        .i_srbusy  (srbusy),
        .o_muxsel  (muxsel),
        .o_srload  (srload),
        .o_latch   (latch),
        .o_cnt_en  (cnt_en),
        .o_overrun (overrun)
`ifdef CTRL_SEQ_ONESHOT_EN
        ,
        .i_trig    (trig)
`endif
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc_p();
        @(posedge clk);
        #1;
    endtask

    task automatic cycles_to_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cnt_en && n < 3000);
    endtask

    task automatic wait_tick(input string nm);
        int n;
        cycles_to_tick(n);
        chk({"tick_timeout_", nm}, cnt_en, 1);
    endtask

    // Scoreboard: compare every cycle, then advance the model with this cycle's inputs.
    initial begin
        bit tick;
        int div;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_sc = 0; m_in = 0; m_armed = 0; m_ch = 0; m_end = -1; m_load = -10;
            end
            tick = (m_sc == 0);
            chk("m_latch",  latch,  !m_in);
            chk("m_srload", srload, m_in && (m_cyc == m_load));
            chk("m_muxsel", muxsel, m_in ? m_ch : 0);
            chk("m_cnt_en", cnt_en, tick);
            chk("m_overrun", overrun, ONESHOT ? (trig && m_in) : (tick && m_in));
            if (rst_n) begin
                div  = freq ? DIV_A : DIV_B;
                m_sc = (m_sc >= div - 1) ? 0 : m_sc + 1;
                if (!m_in) begin
                    if (tick && (!ONESHOT || m_armed || trig)) begin
                        m_in = 1; m_ch = 0; m_load = m_cyc + 1; m_end = -1; m_armed = 0;
                    end else if (ONESHOT && trig) begin
                        m_armed = 1;
                    end
                end else if (m_end >= 0) begin
                    if (m_cyc + 1 == m_end) m_in = 0;
                end else if (m_cyc >= m_load + 2 && !srbusy) begin
                    if (m_ch == NUM_CH - 1) begin
                        m_end = m_cyc + 2;
                    end else begin
                        m_ch++;
                        m_load = m_cyc + 1;
                    end
                end
            end
            m_cyc++;
        end
    end

    // Shift-register stand-in: busy for busy_len cycles after each load.
    initial begin
        int bc;
        bit ls;
        bc = 0;
        forever begin
            @(negedge clk);
            ls = srload;
            @(posedge clk);
            #1;
            if (!rst_n) bc = 0;
            else if (ls) bc = busy_len;
            srbusy = force_busy || (bc > 0);
            if (bc > 0) bc--;
        end
    end

    initial begin
        int n, nl, no, lat_off, pb1, pb2;
        int ld_off[$];
        int ld_mux[$];
        m_cyc = 0;

        repeat (3) cyc_p();
        chk("rst_latch",   latch,   1);
        chk("rst_srload",  srload,  0);
        chk("rst_muxsel",  muxsel,  0);
        chk("rst_cnt_en",  cnt_en,  1);
        chk("rst_overrun", overrun, 0);
        rst_n = 1'b1;

`ifndef CTRL_SEQ_ONESHOT_EN
        // Basic frame: loads every 3 cycles, latch 16 cycles after the first load.
        wait_tick("t1");
        lat_off = -1;
        for (int off = 1; off <= 20; off++) begin
            @(negedge clk);
            if (srload) begin
                ld_off.push_back(off);
                ld_mux.push_back(muxsel);
            end
            if (latch && lat_off < 0) lat_off = off;
        end
        chk("t1_nloads", ld_off.size(), 5);
        for (int i = 0; i < ld_off.size(); i++) begin
            chk("t1_load_off", ld_off[i], 1 + 3 * i);
            chk("t1_load_mux", ld_mux[i], i);
        end
        chk("t1_latch_off", lat_off, 17);
        cycles_to_tick(n);
        chk("t1_period", n + 20, 512);

        // Busy held 10 cycles per load: next load one cycle after busy falls.
        busy_len = 10;
        wait_tick("t2");
        ld_off.delete();
        ld_mux.delete();
        pb1 = 0; pb2 = 0;
        for (int off = 1; off <= 70; off++) begin
            @(negedge clk);
            if (srload) begin
                if (ld_off.size() > 0) begin
                    chk("t2_busy_low_before_load", pb1, 0);
                    chk("t2_busy_high_2_before",   pb2, 1);
                end
                ld_off.push_back(off);
                ld_mux.push_back(muxsel);
            end
            pb2 = pb1;
            pb1 = srbusy;
        end
        chk("t2_nloads", ld_off.size(), 5);
        for (int i = 0; i < ld_off.size(); i++) begin
            chk("t2_load_off", ld_off[i], 1 + 12 * i);
            chk("t2_load_mux", ld_mux[i], i);
        end
        busy_len = 0;

        // Divisor select and early wrap on switching to the smaller divisor.
        wait_tick("t3");
        cyc_p();
        freq = 1'b1;
        cycles_to_tick(n);
        chk("t3_period_a", n, 750);
        repeat (600) @(posedge clk);
        #1;
        freq = 1'b0;
        cycles_to_tick(n);
        chk("t3_wrap", n, 2);
        cycles_to_tick(n);
        chk("t3_period_b", n, 512);

        // Busy stuck across two ticks: two overruns, frame completes, fresh frame follows.
        wait_tick("t4");
        cyc_p();
        force_busy = 1'b1;
        nl = 0; no = 0;
        for (int off = 1; off <= 1033; off++) begin
            @(negedge clk);
            nl += int'(srload);
            no += int'(overrun);
        end
        cyc_p();
        force_busy = 1'b0;
        for (int off = 1034; off <= 1600; off++) begin
            @(negedge clk);
            nl += int'(srload);
            no += int'(overrun);
        end
        chk("t4_overruns", no, 2);
        chk("t4_loads", nl, 10);

        // Asynchronous reset in WAIT on channel 3.
        busy_len = 10;
        wait_tick("t5");
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(srload && muxsel == 3'd3) && n < 100);
        chk("t5_reached_ch3", muxsel, 3);
        repeat (5) cyc_p();
        rst_n = 1'b0;
        #1;
        chk("t5_latch",   latch,   1);
        chk("t5_muxsel",  muxsel,  0);
        chk("t5_srload",  srload,  0);
        chk("t5_cnt_en",  cnt_en,  1);
        chk("t5_overrun", overrun, 0);
        busy_len = 0;
        cyc_p();
        cyc_p();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_rel_latch", latch, 1);
        @(negedge clk);
        chk("t5_rel_srload", srload, 1);
        chk("t5_rel_muxsel", muxsel, 0);
        repeat (30) @(negedge clk);
`else
        // No trigger: ticks pass without frames.
        nl = 0;
        for (int off = 1; off <= 1600; off++) begin
            @(negedge clk);
            nl += int'(srload);
        end
        chk("t6_no_loads", nl, 0);

        // Trigger in LATCH: exactly one frame.
        cyc_p();
        trig = 1'b1;
        cyc_p();
        trig = 1'b0;
        cycles_to_tick(n);
        nl = 0;
        for (int off = 1; off <= 1100; off++) begin
            @(negedge clk);
            nl += int'(srload);
        end
        chk("t7_one_frame", nl, 5);

        // Trigger mid-frame: overrun pulse, no second frame.
        cyc_p();
        trig = 1'b1;
        cyc_p();
        trig = 1'b0;
        wait_tick("t8");
        repeat (4) cyc_p();
        trig = 1'b1;
        @(negedge clk);
        chk("t8_overrun", overrun, 1);
        nl = int'(srload);
        cyc_p();
        trig = 1'b0;
        for (int off = 1; off <= 1100; off++) begin
            @(negedge clk);
            nl += int'(srload);
        end
        chk("t8_no_second_frame", nl, 4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
